// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule constants, FSM state type and round-constant table.
package aes_key_pkg;

  localparam int NK        = 4;
  localparam int NR_AES128 = 10;
  localparam int KEY_W     = 128;

  typedef enum logic [1:0] {IDLE, EXPAND, EMIT} state_t;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte per instance.
module aes_sbox
  import aes_key_pkg::*;
(
  input  logic [7:0] val,
  output logic [7:0] sub
);

  // Entry 0x00 sits in the top byte, so the lookup offset is the complement of val.
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign sub = TABLE[{~val, 3'b000} +: 8];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: streams round keys 10..0 over a valid/ready handshake.
// Optional INV_KEY_DERIVE_EN: key_in is the cipher key and is expanded forward first.
module aes_inv_key_schedule
  import aes_key_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             key_valid,
  input  logic             key_ready,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_idx,
  output logic             last,
  output logic             done
);

  if (NR != NR_AES128) begin : g_nr_check
    $error("aes_inv_key_schedule supports only NR == 10");
  end

  localparam logic [3:0] TOP_IDX = 4'(NR);

  state_t      state;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] b1, b2, b3;
  logic [31:0] sbox_src, rot_word, sub_word, x0;
  logic [3:0]  rc_idx;
  logic [KEY_W-1:0] bwd_key;

  assign {w0, w1, w2, w3} = round_key;

  assign b3 = w3 ^ w2;
  assign b2 = w2 ^ w1;
  assign b1 = w1 ^ w0;

`ifdef INV_KEY_DERIVE_EN
  logic [KEY_W-1:0] fwd_key;

  // The four S-boxes are shared: forward steps read w3, backward steps read the recovered w3.
  assign sbox_src = (state == EXPAND) ? w3 : b3;
  assign rc_idx   = (state == EXPAND) ? round_idx + 4'd1 : round_idx;
`else
  assign sbox_src = b3;
  assign rc_idx   = round_idx;
`endif

  assign rot_word = {sbox_src[23:0], sbox_src[31:24]};

  for (genvar i = 0; i < NK; i++) begin : g_sbox
    aes_sbox u_sbox (
      .val(rot_word[8*i +: 8]),
      .sub(sub_word[8*i +: 8])
    );
  end

  assign x0      = w0 ^ sub_word ^ {rcon(rc_idx), 24'h0};
  assign bwd_key = {x0, b1, b2, b3};

`ifdef INV_KEY_DERIVE_EN
  assign fwd_key = {x0, w1 ^ x0, w2 ^ w1 ^ x0, w3 ^ w2 ^ w1 ^ x0};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      round_key <= '0;
      round_idx <= '0;
      last      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            round_key <= key_in;
            busy      <= 1'b1;
            last      <= 1'b0;
`ifdef INV_KEY_DERIVE_EN
            round_idx <= 4'd0;
            state     <= EXPAND;
`else
            round_idx <= TOP_IDX;
            key_valid <= 1'b1;
            state     <= EMIT;
`endif
          end
        end
`ifdef INV_KEY_DERIVE_EN
        EXPAND: begin
          round_key <= fwd_key;
          round_idx <= round_idx + 4'd1;
          if (round_idx == TOP_IDX - 4'd1) begin
            key_valid <= 1'b1;
            state     <= EMIT;
          end
        end
`endif
        EMIT: begin
          if (key_ready) begin
            if (round_idx != 4'd0) begin
              round_key <= bwd_key;
              round_idx <= round_idx - 4'd1;
              last      <= (round_idx == 4'd1);
            end else begin
              key_valid <= 1'b0;
              busy      <= 1'b0;
              last      <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for aes_inv_key_schedule: vector table plus scoreboard of expected round keys.
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         last;
  logic         done;

  aes_inv_key_schedule #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
    .busy(busy), .key_valid(key_valid), .key_ready(key_ready),
    .round_key(round_key), .round_idx(round_idx), .last(last), .done(done)
  );

  always #5 clk = ~clk;

`ifdef INV_KEY_DERIVE_EN
  localparam int LAT = 11;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [127:0] in_key;
    logic [127:0] exp10;
    logic [127:0] exp0;
    bit           full;
  } vec_t;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           chk_key;
  } exp_t;

  vec_t         vecs [0:1];
  logic [127:0] rk [0:10];
  exp_t         sb [$];
  exp_t         e;
  int           tests = 0;
  int           fails = 0;
  bit           stall = 0;
  bit           exp_done = 0;
  logic [127:0] held_key;
  logic [3:0]   held_idx;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int v);
    exp_t x;
    key_in = vecs[v].in_key;
    start  = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      x.idx     = 4'(i);
      x.chk_key = (i == 10) || (i == 0) || vecs[v].full;
      x.key     = (i == 10) ? vecs[v].exp10 : (i == 0) ? vecs[v].exp0 : vecs[v].full ? rk[i] : '0;
      sb.push_back(x);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int n = 0;
    while (!(key_valid && round_idx == idx) && n < 100) begin
      tick();
      n++;
    end
    check("wait_idx_timeout", 128'(n >= 100), 128'(0));
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check("run_timeout", 128'(busy), 128'(0));
    tick();
    tick();
    check("sb_empty", 128'(sb.size()), 128'(0));
  endtask

  // Transfers are judged at the falling edge, half a cycle before the edge that takes them.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall    = 0;
      exp_done = 0;
    end else begin
      if (exp_done) begin
        check("done_pulse", 128'(done), 128'(1));
        check("busy_after_done", 128'(busy), 128'(0));
        check("valid_after_done", 128'(key_valid), 128'(0));
        exp_done = 0;
      end else begin
        check("no_done", 128'(done), 128'(0));
      end
      if (stall) begin
        check("stall_key", round_key, held_key);
        check("stall_idx", 128'(round_idx), 128'(held_idx));
      end
      stall = 0;
      if (key_valid && key_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_key: got idx %0d key %h, required no transfer", round_idx, round_key);
        end else begin
          e = sb.pop_front();
          check("idx", 128'(round_idx), 128'(e.idx));
          if (e.chk_key) check("key", round_key, e.key);
          check("last", 128'(last), 128'(e.idx == 4'd0));
          if (e.idx == 4'd0) exp_done = 1;
        end
      end else if (key_valid) begin
        stall    = 1;
        held_key = round_key;
        held_idx = round_idx;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit held5;

    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`ifdef INV_KEY_DERIVE_EN
    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, rk[10], rk[0], 1'b1};
    vecs[1] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'h13111d7fe3944a17f307a78b4d2b30c5,
                128'h000102030405060708090a0b0c0d0e0f, 1'b0};
`else
    vecs[0] = '{128'hd014f9a8c9ee2589e13f0cc8b6630ca6, rk[10], rk[0], 1'b1};
    vecs[1] = '{128'h13111d7fe3944a17f307a78b4d2b30c5,
                128'h13111d7fe3944a17f307a78b4d2b30c5,
                128'h000102030405060708090a0b0c0d0e0f, 1'b0};
`endif

    rst_n     = 1'b0;
    start     = 1'b0;
    key_in    = '0;
    key_ready = 1'b0;
    repeat (3) tick();
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_valid", 128'(key_valid), 128'(0));
    check("rst_key", round_key, 128'(0));
    check("rst_idx", 128'(round_idx), 128'(0));
    check("rst_last", 128'(last), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    rst_n = 1'b1;
    tick();

    // Full-rate runs: latency, 11 back-to-back keys, clean finish.
    key_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      start_run(v);
      n = 1;
      while (!key_valid && n < 30) begin
        tick();
        n++;
      end
      check("latency", 128'(n), 128'(LAT));
      n = 0;
      while (key_valid && n < 40) begin
        tick();
        n++;
      end
      check("consecutive_valid", 128'(n), 128'(11));
      tick();
      check("sb_empty", 128'(sb.size()), 128'(0));
    end

    // Random backpressure with a five-cycle hold at round 5.
    key_ready = 1'b0;
    start_run(0);
    n = 0;
    held5 = 0;
    while (busy && n < 400) begin
      if (key_valid && round_idx == 4'd5 && !held5) begin
        key_ready = 1'b0;
        held5 = 1;
        repeat (5) tick();
      end else begin
        key_ready = 1'($urandom_range(0, 1));
        tick();
      end
      n++;
    end
    check("bp_hold_seen", 128'(held5), 128'(1));
    key_ready = 1'b1;
    wait_done();

    // start mid-run and on the final transfer are ignored; start right after done is taken.
    start_run(0);
    wait_idx(4'd7);
    key_in = vecs[1].in_key;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_idx(4'd0);
    key_in = vecs[1].in_key;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("ignored_final_start_busy", 128'(busy), 128'(0));
    check("ignored_final_start_valid", 128'(key_valid), 128'(0));
    start_run(1);
    check("restart_busy", 128'(busy), 128'(1));

    // Reset in the middle of that run aborts it without a done pulse.
    wait_idx(4'd4);
    rst_n     = 1'b0;
    key_ready = 1'b0;
    tick();
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_valid", 128'(key_valid), 128'(0));
    check("midrst_key", round_key, 128'(0));
    check("midrst_idx", 128'(round_idx), 128'(0));
    check("midrst_last", 128'(last), 128'(0));
    check("midrst_done", 128'(done), 128'(0));
    rst_n = 1'b1;
    sb.delete();
    key_ready = 1'b1;
    repeat (3) tick();
    check("post_rst_idle", 128'(busy), 128'(0));
    start_run(0);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
Decryption-side counterpart of the forward key-expansion step. It takes the final (round-10) AES-128 round key and walks the schedule backwards, streaming round keys 10, 9, … 0, one per handshake, to the inverse-cipher datapath. Each backward step undoes one forward g-function step: the word XOR chain is reversed, then SubWord(RotWord()) plus Rcon is removed. It sits between the key-load interface and the InvAddRoundKey stage of the decrypt core.

Parameters:
NR, 10, number of rounds; only 10 is legal (AES-128); elaboration error otherwise.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  single-cycle request to begin a schedule run using key_in
key_in  input  128  round-10 key (cipher key when INV_KEY_DERIVE_EN is defined); MSB = w0 byte 0
busy  output  1  high from accepted start until the round-0 key transfers
key_valid  output  1  round_key/round_idx are valid
key_ready  input  1  consumer accepts the current key
round_key  output  128  current round key, registered
round_idx  output  4  round number of round_key, 10 down to 0
last  output  1  high with key_valid when round_idx == 0
done  output  1  one-cycle pulse the cycle after the round-0 key transfers

Behaviour:
- Reset: when rst_n is low at a rising clk edge, busy=0, key_valid=0, round_key=0, round_idx=0, last=0, done=0, and the FSM returns to IDLE. Reset mid-run aborts the run; no partial done pulse is produced.
- FSM states: IDLE, EMIT (plus EXPAND with the optional feature).
- IDLE: start=1 loads key_reg<=key_in and round_idx<=10, then moves to EMIT. The next cycle shows key_valid=1, so latency from start to first valid is 1 cycle.
- start while busy=1 is ignored; key_in is sampled only on an accepted start.
- EMIT: key_valid=1. round_key and round_idx are held stable while key_ready=0.
- Transfer occurs when key_valid && key_ready.
  - Transfer with round_idx>0: in the same cycle, compute the previous key and decrement round_idx. key_valid stays high, so back-to-back transfers give one key per cycle.
  - Transfer with round_idx==0: key_valid<=0, busy<=0, done<=1 for one cycle, return to IDLE.
- Backward step, from round i to i-1, with words w0..w3 (w0 = bits 127:96):
  - w3' = w3^w2
  - w2' = w2^w1
  - w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[i],24'h0}
  - RotWord(a,b,c,d) = (b,c,d,a).
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- The step is purely combinational from key_reg and is registered on transfer. Critical path: 4 S-box lookups plus 3 XOR levels.
- start in the same cycle as the final transfer is ignored (the FSM is still in EMIT). The first start accepted is the one in the cycle after done.

Optional Feature:
INV_KEY_DERIVE_EN
- Defined: key_in is the cipher key (round 0). An accepted start enters EXPAND: 10 forward steps, one per cycle, reusing the same S-box instances through a direction mux. Forward step: w0'=w0^SubWord(RotWord(w3))^Rcon[i], then w1'=w1^w0', and so on. During EXPAND, busy=1 and key_valid=0. The FSM then enters EMIT with round_idx=10, so start-to-first-valid latency is 11 cycles.
- Undefined: EXPAND state and direction mux are absent; key_in is the round-10 key; latency is 1 cycle.

Decomposition:
- Package aes_key_pkg holds:
  - the RCON table function, rcon(i) for i in 1..10
  - the state enum {IDLE, EXPAND, EMIT}
  - constants NK=4, NR_AES128=10, KEY_W=128.
- Sub-module aes_sbox: 8-bit combinational forward S-box, instantiated 4× for SubWord.

Test Plan:
- FIPS-197 A.1: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1 → idx10 = input, idx9 = ac7766f319fadc2128d12941575c006e, …, idx0 = 2b7e151628aed2a6abf7158809cf4f3c with last=1; done one cycle later; 11 consecutive valid cycles.
- Backpressure: same run with key_ready toggled randomly (and held low 5 cycles at idx5) → round_key and idx stay stable while stalled, sequence is identical, no key skipped or repeated.
- Second vector: key_in=13111d7fe3944a17f307a78b4d2b30c5 → idx0 = 000102030405060708090a0b0c0d0e0f.
- start pulsed at idx7 with a different key_in → ignored; the sequence completes with the original key.
- rst_n=0 at idx4 → next cycle all outputs are 0, busy=0, no done; a fresh start after reset works normally.
- INV_KEY_DERIVE_EN build: key_in=2b7e151628aed2a6abf7158809cf4f3c → first valid 11 cycles after start with d014f9a8c9ee2589e13f0cc8b6630ca6 at idx10; idx0 returns the input key.
